z_run_monitor: RTL and testbench
================================

// Module: z_run_monitor
// PURPOSE
//  Downstream consumer of the pulse-stretch FSM's z output. Measures each
//  contiguous high run of z and flags runs that hit the saturation limit,
//  i.e. the count-out that forces the FSM back to EH. Queues one record
//  per run in a small FIFO, drained through a valid/ready interface.
// PARAMETERS
//  CNT_W       5   width of the run-length field; requires MAX_RUN < 2**CNT_W
//  MAX_RUN     19  run length at which a run is saturated (FSM count limit 18 + 1); >= 2
//  FIFO_DEPTH  4   record queue depth; power of 2, >= 2
// PORTS
//  clk        in   1      single clock; all state updates on posedge
//  init       in   1      synchronous, active-high reset
//  z_in       in   1      z from the upstream FSM, synchronous to clk
//  rec_valid  out  1      head record available
//  rec_ready  in   1      consumer accepts head record this cycle
//  rec_len    out  CNT_W  head record run length in cycles (1..MAX_RUN)
//  rec_sat    out  1      head record run reached MAX_RUN
//  overflow   out  1      sticky: at least one record was dropped
//  busy       out  1      a run is currently being measured (state != IDLE)
// BEHAVIOUR
//  Reset (init=1 at posedge): state=IDLE, run_cnt=0, FIFO empty.
//   rec_valid=0, rec_len=0, rec_sat=0, overflow=0, busy=0.
//   A partial run in progress is discarded and no record is produced.
//  FSM, sampled on each posedge:
//   IDLE: z_in=1 -> RUN, run_cnt=1. z_in=0 -> stay in IDLE.
//   RUN, z_in=1, run_cnt+1 <  MAX_RUN -> run_cnt++, stay in RUN.
//   RUN, z_in=1, run_cnt+1 == MAX_RUN -> push {MAX_RUN,sat=1}, go to HOLD.
//   RUN, z_in=0 -> push {run_cnt,sat=0}, go to IDLE (run_cnt cleared).
//   HOLD: z_in=1 -> stay; no further push. z_in=0 -> IDLE.
//   A run therefore produces exactly one record. A saturated run never yields a second record.
//   Falling edge in IDLE on the same cycle a new high arrives is impossible
//   (1-bit input); back-to-back runs need at least one z_in=0 sample between them.
//  Latency: the record is visible (rec_valid=1) on the cycle after the push edge.
//   For a saturated run, that is 1 cycle after the MAX_RUN-th high sample,
//   not after z falls.
//  Handshake: pop occurs when rec_valid & rec_ready at posedge.
//   rec_len and rec_sat hold stable while rec_valid=1 and no pop occurs.
//   rec_ready with an empty FIFO is ignored.
//  Full FIFO and push, no pop: the record is dropped and overflow set to 1.
//   overflow stays set until init.
//  Full FIFO and push with pop in the same cycle: the push is accepted and the
//   count is unchanged.
//  Empty FIFO and push: rec_valid rises next cycle. There is no bypass on the same cycle.
//  Pointers wrap modulo FIFO_DEPTH. The count is CLOG2(FIFO_DEPTH)+1 bits.
//  When the FIFO is empty, rec_len and rec_sat hold their last values. Only reset forces them to 0.
// STRUCTURE
//  Package zmon_pkg: state encoding IDLE/RUN/HOLD as a typedef enum, default
//   MAX_RUN/CNT_W localparams, and the record struct {len, sat}.
//  Sub-module mon_fifo: sync FIFO with parameterised width/depth, push/pop/full/empty,
//   and synchronous active-high reset on init.
//  Top: FSM + run counter + overflow flag, instancing mon_fifo.
// TESTING
//  1. z_in high 3 cycles then low, rec_ready=1
//     -> one record len=3 sat=0; rec_valid for 1 cycle.
//  2. z_in high 25 cycles -> one record len=19 sat=1, pushed at the 19th high sample.
//     busy stays 1 until z_in falls; no second record.
//  3. rec_ready=0; five runs of lengths 1,2,3,4,5 -> 4 records held, the 5th dropped.
//     overflow=1; draining yields 1,2,3,4 in order.
//  4. FIFO full, rec_ready=1 on the cycle a run ends -> no drop, overflow=0.
//     Order is preserved.
//  5. init=1 in the middle of a 10-cycle run, then low with z_in still high -> no record for the cut run.
//     A new run starts only after z_in is sampled 0 then 1; outputs are at reset values.
//  6. Closed loop with upstream FSM: q sequence 0,0,1,1,0,1,0,0,0,1,1 then q=0 held
//     -> a single sat=1 record of len 19 once the FSM enters C and counts out.

Source files
------------

// File: rtl/zmon_pkg.sv
// Shared definitions for the z run monitor.
//   zmon_state_t : run-measurement FSM states
//   zmon_rec_t   : one queued record {len, sat} at the default field width
//   ZMON_*       : default parameter values for the monitor and its FIFO
package zmon_pkg;

  localparam int unsigned ZMON_CNT_W      = 5;
  localparam int unsigned ZMON_MAX_RUN    = 19;
  localparam int unsigned ZMON_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } zmon_state_t;

  typedef struct packed {
    logic [ZMON_CNT_W-1:0] len;
    logic                  sat;
  } zmon_rec_t;

endpackage

// File: rtl/mon_fifo.sv
// Synchronous record FIFO for the z run monitor.
//   clk, init   : clock and synchronous active-high reset
//   push, din   : write request and data (dropped when full unless popping)
//   pop         : read request (ignored when empty)
//   dout        : head entry; holds the last shown value while empty
//   full, empty : occupancy flags
module mon_fifo #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             init,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic [WIDTH-1:0] last_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop frees a slot on the same edge, so a push into a full FIFO is
  // accepted when it coincides with a pop.
  assign do_push = push & (~full | do_pop);

  // Once the FIFO drains, the head slot is stale; show the value that was
  // last presented instead so the outputs stay put until reset.
  assign dout = empty ? last_q : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (init) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      last_q <= '0;
    end else begin
      last_q <= dout;
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/z_run_monitor.sv
// Measures each contiguous high run of z_in, queues one {len, sat} record
// per run and presents the records through a valid/ready interface.
//   clk        : clock
//   init       : synchronous active-high reset
//   z_in       : monitored z signal
//   rec_valid  : head record available
//   rec_ready  : consumer takes the head record this cycle
//   rec_len    : head record run length (1..MAX_RUN)
//   rec_sat    : head record reached MAX_RUN
//   overflow   : sticky, a record was dropped on a full FIFO
//   busy       : a run is being measured
module z_run_monitor
  import zmon_pkg::*;
#(
  parameter int unsigned CNT_W      = ZMON_CNT_W,
  parameter int unsigned MAX_RUN    = ZMON_MAX_RUN,
  parameter int unsigned FIFO_DEPTH = ZMON_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             init,
  input  logic             z_in,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [CNT_W-1:0] rec_len,
  output logic             rec_sat,
  output logic             overflow,
  output logic             busy
);

  typedef struct packed {
    logic [CNT_W-1:0] len;
    logic             sat;
  } rec_w_t;

  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_RUN);

  zmon_state_t      state_q;
  zmon_state_t      state_d;
  logic [CNT_W-1:0] run_q;
  logic [CNT_W-1:0] run_d;
  logic             armed_q;
  logic             armed_d;
  logic             overflow_q;
  logic             push;
  rec_w_t           push_rec;
  rec_w_t           head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;

  always_ff @(posedge clk) begin
    if (init) begin
      state_q    <= IDLE;
      run_q      <= '0;
      armed_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      armed_q <= armed_d;
      if (push & fifo_full & ~pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // armed_q: after reset z_in may still be high from a cut run; a new run
  // may only start once z_in has been seen low.
  always_comb begin
    state_d      = state_q;
    run_d        = run_q;
    armed_d      = armed_q;
    push         = 1'b0;
    push_rec.len = run_q;
    push_rec.sat = 1'b0;
    case (state_q)
      IDLE: begin
        if (!armed_q) begin
          if (!z_in) begin
            armed_d = 1'b1;
          end
        end else if (z_in) begin
          state_d = RUN;
          run_d   = CNT_W'(1);
        end
      end
      RUN: begin
        if (z_in) begin
          if (run_q == MAX_LEN - 1'b1) begin
            push         = 1'b1;
            push_rec.len = MAX_LEN;
            push_rec.sat = 1'b1;
            run_d        = MAX_LEN;
            state_d      = HOLD;
          end else begin
            run_d = run_q + 1'b1;
          end
        end else begin
          push    = 1'b1;
          state_d = IDLE;
          run_d   = '0;
        end
      end
      HOLD: begin
        if (!z_in) begin
          state_d = IDLE;
          run_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        run_d   = '0;
      end
    endcase
  end

  assign rec_valid = ~fifo_empty;
  assign pop       = rec_valid & rec_ready;
  assign rec_len   = head.len;
  assign rec_sat   = head.sat;
  assign overflow  = overflow_q;
  assign busy      = (state_q != IDLE);

  mon_fifo #(
    .WIDTH (CNT_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .init  (init),
    .push  (push),
    .pop   (pop),
    .din   (push_rec),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_z_run_monitor.sv
module tb_z_run_monitor;
  import zmon_pkg::*;

  localparam int unsigned MAX_RUN = 19;
  localparam int unsigned DEPTH   = 4;

  logic       clk = 1'b0;
  logic       init = 1'b1;
  logic       z_in = 1'b0;
  logic       rec_ready = 1'b0;
  logic       rec_valid;
  logic [4:0] rec_len;
  logic       rec_sat;
  logic       overflow;
  logic       busy;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference: queue of records, count of consecutive highs, arm flag.
  zmon_rec_t   mq[$];
  zmon_rec_t   m_last;
  bit          m_ov;
  int unsigned m_run;
  bit          m_armed;

  z_run_monitor #(
    .CNT_W      (5),
    .MAX_RUN    (MAX_RUN),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .init      (init),
    .z_in      (z_in),
    .rec_valid (rec_valid),
    .rec_ready (rec_ready),
    .rec_len   (rec_len),
    .rec_sat   (rec_sat),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic zmon_rec_t m_shown();
    return (mq.size() != 0) ? mq[0] : m_last;
  endfunction

  task automatic model_step(input bit z, input bit rdy, input bit ini);
    zmon_rec_t r;
    bit        have;
    if (ini) begin
      mq.delete();
      m_ov    = 1'b0;
      m_run   = 0;
      m_armed = 1'b0;
      m_last  = '0;
      return;
    end
    m_last = m_shown();
    if (rdy && mq.size() != 0) void'(mq.pop_front());
    have = 1'b0;
    r    = '0;
    if (!m_armed) begin
      if (!z) m_armed = 1'b1;
    end else if (z) begin
      m_run++;
      if (m_run == MAX_RUN) begin
        have  = 1'b1;
        r.len = 5'(MAX_RUN);
        r.sat = 1'b1;
      end
    end else begin
      if (m_run > 0 && m_run < MAX_RUN) begin
        have  = 1'b1;
        r.len = 5'(m_run);
        r.sat = 1'b0;
      end
      m_run = 0;
    end
    if (have) begin
      if (mq.size() < DEPTH) mq.push_back(r);
      else m_ov = 1'b1;
    end
  endtask

  task automatic compare_all();
    zmon_rec_t s;
    s = m_shown();
    check("valid", rec_valid, (mq.size() != 0) ? 1 : 0);
    check("len", rec_len, s.len);
    check("sat", rec_sat, s.sat);
    check("overflow", overflow, m_ov);
    check("busy", busy, (m_armed && m_run > 0) ? 1 : 0);
  endtask

  // Called at a negedge: apply inputs for the next posedge, then compare.
  task automatic tick(input bit z, input bit rdy, input bit ini);
    z_in      = z;
    rec_ready = rdy;
    init      = ini;
    model_step(z, rdy, ini);
    @(negedge clk);
    compare_all();
  endtask

  task automatic run_of(input int unsigned n, input bit rdy);
    for (int unsigned i = 0; i < n; i++) tick(1'b1, rdy, 1'b0);
  endtask

  initial begin
    int unsigned seg_len;
    int unsigned gap;
    bit          rdy;

    @(negedge clk);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    check("rst_valid", rec_valid, 0);
    check("rst_len", rec_len, 0);
    check("rst_busy", busy, 0);

    // 1: short run, consumer ready
    tick(1'b0, 1'b1, 1'b0);
    run_of(3, 1'b1);
    tick(1'b0, 1'b1, 1'b0);
    check("t1_valid", rec_valid, 1);
    check("t1_len", rec_len, 3);
    check("t1_sat", rec_sat, 0);
    tick(1'b0, 1'b1, 1'b0);
    check("t1_popped", rec_valid, 0);

    // 2: long run saturates at the 19th high sample
    run_of(18, 1'b0);
    check("t2_pre", rec_valid, 0);
    run_of(1, 1'b0);
    check("t2_valid", rec_valid, 1);
    check("t2_len", rec_len, 19);
    check("t2_sat", rec_sat, 1);
    run_of(6, 1'b0);
    check("t2_busy", busy, 1);
    tick(1'b0, 1'b0, 1'b0);
    check("t2_idle", busy, 0);
    tick(1'b0, 1'b1, 1'b0);
    check("t2_single", rec_valid, 0);

    // 3: overflow with consumer stalled
    for (int unsigned k = 1; k <= 5; k++) begin
      run_of(k, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
    end
    check("t3_ovf", overflow, 1);
    for (int unsigned k = 1; k <= 4; k++) begin
      check("t3_order", rec_len, k);
      tick(1'b0, 1'b1, 1'b0);
    end
    check("t3_empty", rec_valid, 0);
    check("t3_hold", rec_len, 4);

    // 4: push into a full FIFO together with a pop
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    for (int unsigned k = 1; k <= 4; k++) begin
      run_of(k, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
    end
    run_of(5, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check("t4_noovf", overflow, 0);
    for (int unsigned k = 2; k <= 5; k++) begin
      check("t4_order", rec_len, k);
      tick(1'b0, 1'b1, 1'b0);
    end
    check("t4_empty", rec_valid, 0);

    // 5: reset cuts a run; z_in must drop before a new run starts
    tick(1'b0, 1'b0, 1'b0);
    run_of(5, 1'b0);
    tick(1'b1, 1'b0, 1'b1);
    check("t5_valid", rec_valid, 0);
    check("t5_len", rec_len, 0);
    check("t5_busy", busy, 0);
    run_of(4, 1'b0);
    check("t5_noarm", busy, 0);
    tick(1'b0, 1'b0, 1'b0);
    check("t5_nocut", rec_valid, 0);
    tick(1'b1, 1'b0, 1'b0);
    check("t5_rearm", busy, 1);
    tick(1'b0, 1'b0, 1'b0);
    check("t5_len1", rec_len, 1);

    // Randomized runs, consumer back-pressure and rare resets
    for (int unsigned s = 0; s < 160; s++) begin
      seg_len = $urandom_range(1, 24);
      gap     = $urandom_range(1, 3);
      for (int unsigned i = 0; i < seg_len + gap; i++) begin
        rdy = ((s / 40) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
        tick((i < seg_len) ? 1'b1 : 1'b0, rdy, ($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
